ori_hist32: RTL
===============

# ori_hist32

Dominant-orientation histogram stage of the SIFT orientation-assignment path. It sits directly downstream of the 32-bin gradient-direction ROM. Per keypoint window, it accumulates gradient magnitude into 32 direction bins, then scans the bins and reports the peak bin index and its accumulated weight to the descriptor stage.

## Interface
- MAG_W, 8, width of input gradient magnitude
- ACC_W, 16, width of each histogram bin accumulator; must satisfy ACC_W >= MAG_W

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; clears histogram and opens a new window (accepted only in IDLE)
- in_valid  input  1  sample qualifier for in_dir/in_mag/in_last
- in_dir  input  5  direction bin from the direction ROM, 0..31
- in_mag  input  MAG_W  gradient magnitude weight, unsigned
- in_last  input  1  marks final sample of the window (valid only with in_valid)
- in_ready  output  1  high when state is ACCUM; samples are accepted when in_valid && in_ready
- busy  output  1  high whenever state is not IDLE
- out_valid  output  1  one-cycle pulse carrying the window result
- out_bin  output  5  index of peak bin
- out_peak  output  ACC_W  accumulated weight of peak bin

## Operation
- Storage: 32 × ACC_W bin registers (hist[0..31]), a 5-bit scan index, a running max value, and a running max index.
- FSM states: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - start=1 clears all hist[] to 0 and moves to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - An accepted sample updates hist[in_dir] <= sat(hist[in_dir] + in_mag), zero-extended to ACC_W.
  - Saturation is at 2^ACC_W−1; the sum never wraps.
  - Back-to-back samples to the same bin must accumulate correctly every cycle (single-cycle read-modify-write, no hazard).
  - An accepted sample with in_last=1 is accumulated and the FSM moves to SCAN with idx=0, max=0, maxidx=0.
  - start is ignored in ACCUM.
- SCAN:
  - One bin per cycle, idx 0..31.
  - If hist[idx] > max (strictly greater), then max <= hist[idx] and maxidx <= idx. Ties therefore resolve to the lowest index.
  - After idx=31 is evaluated, the FSM moves to DONE. idx wraps to 0; the wrap is unused.
  - in_valid is ignored and hist[] is frozen during SCAN.
- DONE:
  - out_valid=1 for exactly this cycle, with out_bin=maxidx and out_peak=max.
  - Next state is IDLE.
  - start is ignored in DONE. A new window may start on the first IDLE cycle.
- All-zero histogram (every sample had in_mag=0): out_bin=0, out_peak=0.
- out_bin and out_peak hold their last values until the next DONE. They are meaningful only while out_valid=1.
- Reset (rst_n=0, any state, including mid-ACCUM or mid-SCAN) takes effect immediately:
  - FSM goes to IDLE and hist[] is cleared.
  - idx, max and maxidx go to 0.
  - in_ready=0, busy=0, out_valid=0, out_bin=0, out_peak=0.
  - The partial window is discarded and no out_valid is produced for it.

## Timing
- Outputs are registered. in_ready and busy decode from the state register.
- start sampled in cycle S: ACCUM and in_ready=1 from cycle S+1.
- Last sample accepted in cycle T:
  - SCAN occupies cycles T+1..T+32.
  - out_valid=1 in cycle T+33 (DONE).
  - IDLE in T+34; the earliest accepted start is in T+34.
- Fixed latency from last sample to result is 33 cycles, independent of sample count.
- Minimum window is one sample (in_last on the first accepted sample).
- There is no backpressure on the output; the consumer must take out_valid when it pulses.

## Test plan
- Reset then idle: all outputs 0. start → in_ready=1 next cycle. One sample dir=5, mag=10, last=1 → out_valid exactly 33 cycles later with out_bin=5, out_peak=10, then busy=0.
- Accumulation: samples (3,20), (7,15), (3,4), (7,10), last on the final sample → out_bin=7, out_peak=25. A back-to-back pair to bin 3 must sum to 24 (not 20 or 4).
- Tie and zero: bins 9 and 2 each get 50 → out_bin=2, out_peak=50. A window of all mag=0 → out_bin=0, out_peak=0.
- Saturation (ACC_W=16, MAG_W=8): 300 samples dir=31, mag=255 → out_bin=31, out_peak=16'hFFFF.
- Ignored inputs: in_valid pulses during IDLE, SCAN and DONE, and start pulses during ACCUM and SCAN, leave hist[] unchanged. The result of a prior known window must be unchanged and timing must stay 33 cycles.
- Reset mid-operation: assert rst_n=0 during ACCUM and again during SCAN. Outputs go to 0 immediately and no out_valid appears. A fresh window afterwards reports only its own samples, showing the old bins were cleared.

Source files
------------

// File: rtl/ori_hist32_if.sv
// Sample/result bundle between the direction ROM, the orientation histogram and the descriptor stage.
interface ori_hist32_if #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
);
  logic             start;
  logic             in_valid;
  logic [4:0]       in_dir;
  logic [MAG_W-1:0] in_mag;
  logic             in_last;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic [4:0]       out_bin;
  logic [ACC_W-1:0] out_peak;

  modport master (
    output start, in_valid, in_dir, in_mag, in_last,
    input  in_ready, busy, out_valid, out_bin, out_peak
  );

  modport slave (
    input  start, in_valid, in_dir, in_mag, in_last,
    output in_ready, busy, out_valid, out_bin, out_peak
  );
endinterface

// File: rtl/ori_hist32.sv
// Dominant-orientation histogram: accumulates magnitude into 32 direction bins per window,
// then scans for the peak bin (lowest index wins ties) and reports it once.
//
// state   | meaning
// S_IDLE  | waiting for start; inputs ignored
// S_ACCUM | accepting samples into hist, in_last ends the window
// S_SCAN  | one bin per cycle, tracking running max and its index
// S_DONE  | out_valid high for this cycle only
module ori_hist32 #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  ori_hist32_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] hist_q [32];
  logic [4:0]       idx_q;
  logic [ACC_W-1:0] max_q;
  logic [4:0]       maxidx_q;
  logic             out_valid_q;
  logic [4:0]       out_bin_q;
  logic [ACC_W-1:0] out_peak_q;

  logic [ACC_W:0]   bin_sum_d;
  logic [ACC_W-1:0] bin_sat_d;
  logic             scan_gt_d;
  logic [ACC_W-1:0] scan_max_d;
  logic [4:0]       scan_idx_d;

  // One extra carry bit detects overflow so the bin clamps instead of wrapping.
  assign bin_sum_d  = {1'b0, hist_q[bus.in_dir]} + {{(ACC_W + 1 - MAG_W){1'b0}}, bus.in_mag};
  assign bin_sat_d  = bin_sum_d[ACC_W] ? '1 : bin_sum_d[ACC_W-1:0];

  assign scan_gt_d  = hist_q[idx_q] > max_q;
  assign scan_max_d = scan_gt_d ? hist_q[idx_q] : max_q;
  assign scan_idx_d = scan_gt_d ? idx_q : maxidx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 32; i++) hist_q[i] <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      maxidx_q    <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_peak_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 32; i++) hist_q[i] <= '0;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            hist_q[bus.in_dir] <= bin_sat_d;
            if (bus.in_last) begin
              idx_q    <= '0;
              max_q    <= '0;
              maxidx_q <= '0;
              state_q  <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          max_q    <= scan_max_d;
          maxidx_q <= scan_idx_d;
          idx_q    <= idx_q + 5'd1;
          // Result registers load on the last scan step so out_valid lines up with S_DONE.
          if (idx_q == 5'd31) begin
            out_valid_q <= 1'b1;
            out_bin_q   <= scan_idx_d;
            out_peak_q  <= scan_max_d;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_peak  = out_peak_q;

endmodule
